// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the two-input stream multiplexer.
package stream_mux_pkg;

    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic {
        SRC0 = 1'b0,
        SRC1 = 1'b1
    } src_e;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCK0    = 2'd1,
        LOCK1    = 2'd2
    } lock_state_e;

    function automatic src_e other_src(input src_e s);
        return (s == SRC0) ? SRC1 : SRC0;
    endfunction

endpackage

// File: rtl/stream_mux_2to1_reg_slice.sv
// Single-entry output register for a valid/ready stream; slot_free says a new beat may load this cycle.
module stream_reg_slice #(
    parameter int PAYLOAD_W = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [PAYLOAD_W-1:0] load_payload,
    input  logic                 out_ready,
    output logic                 slot_free,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_payload
);

    // The held beat leaves when out_ready is high, so a load in the same cycle replaces it without a bubble.
    assign slot_free = ~out_valid | out_ready;

    // Beat register: load wins over drain; callers only load while slot_free is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_payload <= {PAYLOAD_W{1'b0}};
        end else if (load) begin
            out_valid   <= 1'b1;
            out_payload <= load_payload;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_mux_2to1.sv
// Round-robin 2:1 stream merge with a registered output tagged by source index.
// Optional packet locking (in*_last / out_last ports) is built when STREAM_MUX_LOCK_EN is defined.
module stream_mux_2to1
    import stream_mux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [DATA_W-1:0] in1_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sel
`ifdef STREAM_MUX_LOCK_EN
    ,
    input  logic              in0_last,
    input  logic              in1_last,
    output logic              out_last
`endif
);

`ifdef STREAM_MUX_LOCK_EN
    localparam int PAYLOAD_W = DATA_W + 2;
    lock_state_e lock_r;
    logic        acc_last_s;
`else
    localparam int PAYLOAD_W = DATA_W + 1;
`endif

    logic                 slot_free_s;
    logic                 grant0_s;
    logic                 grant1_s;
    logic                 accept_s;
    src_e                 prio_r;
    src_e                 served_s;
    logic [DATA_W-1:0]    acc_data_s;
    logic [PAYLOAD_W-1:0] load_payload_s;
    logic [PAYLOAD_W-1:0] out_payload_s;

    // Arbitration: a held lock pins the grant, otherwise a lone requester wins and ties go to prio.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (!rst_n) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
`ifdef STREAM_MUX_LOCK_EN
        else if (lock_r == LOCK0) begin
            grant0_s = in0_valid;
        end else if (lock_r == LOCK1) begin
            grant1_s = in1_valid;
        end
`endif
        else if (in0_valid && in1_valid) begin
            grant0_s = (prio_r == SRC0);
            grant1_s = (prio_r == SRC1);
        end else begin
            grant0_s = in0_valid;
            grant1_s = in1_valid;
        end
    end

    assign in0_ready  = grant0_s & slot_free_s;
    assign in1_ready  = grant1_s & slot_free_s;
    assign accept_s   = in0_ready | in1_ready;
    assign served_s   = in1_ready ? SRC1 : SRC0;
    assign acc_data_s = in1_ready ? in1_data : in0_data;

`ifdef STREAM_MUX_LOCK_EN
    assign acc_last_s     = in1_ready ? in1_last : in0_last;
    assign load_payload_s = {acc_last_s, served_s, acc_data_s};
    assign out_last       = out_payload_s[DATA_W+1];
`else
    assign load_payload_s = {served_s, acc_data_s};
`endif

    stream_reg_slice #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_slice (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (accept_s),
        .load_payload (load_payload_s),
        .out_ready    (out_ready),
        .slot_free    (slot_free_s),
        .out_valid    (out_valid),
        .out_payload  (out_payload_s)
    );

    assign out_data = out_payload_s[DATA_W-1:0];
    assign out_sel  = out_payload_s[DATA_W];

    // Priority pointer (and packet lock) advance only on accepted beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_r <= SRC0;
`ifdef STREAM_MUX_LOCK_EN
            lock_r <= UNLOCKED;
`endif
        end else if (accept_s) begin
`ifdef STREAM_MUX_LOCK_EN
            if (acc_last_s) begin
                prio_r <= other_src(served_s);
                lock_r <= UNLOCKED;
            end else begin
                lock_r <= (served_s == SRC1) ? LOCK1 : LOCK0;
            end
`else
            prio_r <= other_src(served_s);
`endif
        end
    end

endmodule

// File: tb/tb_stream_mux_2to1.sv
// Self-checking bench for stream_mux_2to1: vector table, reset/lock sequences, randomized run vs. a queue model.
module tb_stream_mux_2to1;
    import stream_mux_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in0_valid, in1_valid, out_ready;
    logic [W-1:0] in0_data, in1_data, out_data;
    logic         in0_ready, in1_ready, out_valid, out_sel;
`ifdef STREAM_MUX_LOCK_EN
    logic         in0_last, in1_last, out_last;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    stream_mux_2to1 #(.DATA_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_data  (in0_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_data  (in1_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
`ifdef STREAM_MUX_LOCK_EN
        ,
        .in0_last  (in0_last),
        .in1_last  (in1_last),
        .out_last  (out_last)
`endif
    );

    typedef struct {
        logic         v0;
        logic [W-1:0] d0;
        logic         v1;
        logic [W-1:0] d1;
        logic         ordy;
        logic         r0;
        logic         r1;
        logic         ov;
        logic         sel;
        logic [W-1:0] od;
    } vec_t;

    typedef struct {
        logic         l;
        logic         s;
        logic [W-1:0] d;
    } beat_t;

    vec_t tbl[16];

    function automatic vec_t mk(logic v0, logic [W-1:0] d0, logic v1, logic [W-1:0] d1, logic ordy,
                                logic r0, logic r1, logic ov, logic sel, logic [W-1:0] od);
        vec_t v;
        v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.ordy = ordy;
        v.r0 = r0; v.r1 = r1; v.ov = ov; v.sel = sel; v.od = od;
        return v;
    endfunction

    task automatic drive(logic v0, logic [W-1:0] d0, logic l0, logic v1, logic [W-1:0] d1, logic l1, logic ordy);
        in0_valid = v0; in0_data = d0;
        in1_valid = v1; in1_data = d1;
        out_ready = ordy;
`ifdef STREAM_MUX_LOCK_EN
        in0_last = l0;
        in1_last = l1;
`endif
    endtask

    // out_sel/out_data (and out_last) are only meaningful while out_valid is high.
    task automatic check_outs(string name, logic er0, logic er1, logic eov, logic esel, logic [W-1:0] eod, logic elast);
        logic ok;
        vectors++;
        ok = (in0_ready === er0) && (in1_ready === er1) && (out_valid === eov) &&
             (!eov || ((out_sel === esel) && (out_data === eod)));
`ifdef STREAM_MUX_LOCK_EN
        ok = ok && (!eov || (out_last === elast));
`endif
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got r0=%b r1=%b ov=%b sel=%b data=%h, want r0=%b r1=%b ov=%b sel=%b data=%h last=%b",
                     name, in0_ready, in1_ready, out_valid, out_sel, out_data, er0, er1, eov, esel, eod, elast);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    beat_t q[$];
    logic         sv[2];
    logic [W-1:0] sd[2];
    logic         sl[2];
    int           prio_m;
    int           lock_m;

    initial begin
        // Reset with both sources requesting: nothing may be accepted or presented.
        rst_n = 1'b0;
        drive(1'b1, 8'hA5, 1'b0, 1'b1, 8'hB5, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check_outs("reset_outputs", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        vectors++;
        if (out_data !== 8'h00 || out_sel !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_payload: got data=%h sel=%b, want data=00 sel=0", out_data, out_sel);
        end
        rst_n = 1'b1;
        #1;
        check_outs("first_grant", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        do_reset();

        tbl[0]  = mk(1'b0, 8'h00, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        tbl[1]  = mk(1'b0, 8'h00, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11);
        tbl[2]  = mk(1'b0, 8'h00, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22);
        tbl[3]  = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33);
        tbl[4]  = mk(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        tbl[5]  = mk(1'b1, 8'hA1, 1'b1, 8'hB0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA0);
        tbl[6]  = mk(1'b1, 8'hA1, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB0);
        tbl[7]  = mk(1'b1, 8'hA2, 1'b1, 8'hB1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA1);
        tbl[8]  = mk(1'b1, 8'h5C, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB1);
        tbl[9]  = mk(1'b1, 8'h5D, 1'b1, 8'hE0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5C);
        tbl[10] = mk(1'b1, 8'h5D, 1'b1, 8'hE0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5C);
        tbl[11] = mk(1'b1, 8'h5D, 1'b1, 8'hE0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5C);
        tbl[12] = mk(1'b1, 8'h5D, 1'b1, 8'hE0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5C);
        tbl[13] = mk(1'b1, 8'h5D, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hE0);
        tbl[14] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5D);
        tbl[15] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            drive(tbl[i].v0, tbl[i].d0, 1'b1, tbl[i].v1, tbl[i].d1, 1'b1, tbl[i].ordy);
            @(negedge clk);
            check_outs($sformatf("vec%0d", i), tbl[i].r0, tbl[i].r1, tbl[i].ov, tbl[i].sel, tbl[i].od, 1'b1);
        end

        // Asynchronous reset while a beat is held under backpressure.
        @(posedge clk);
        #1;
        drive(1'b1, 8'h77, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        check_outs("held_before_reset", 1'b0, 1'b0, 1'b1, 1'b0, 8'h77, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef STREAM_MUX_LOCK_EN
        begin
            logic [W-1:0] d0s[5]  = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC3};
            logic         l0s[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
            logic         v1s[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
            logic         er0s[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
            logic         eovs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
            logic         esel[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            logic [W-1:0] eod[5]  = '{8'h00, 8'hC0, 8'hC1, 8'hC2, 8'hD0};
            logic         elst[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
            for (int i = 0; i < 5; i++) begin
                @(posedge clk);
                #1;
                drive(1'b1, d0s[i], l0s[i], v1s[i], 8'hD0, 1'b1, 1'b1);
                @(negedge clk);
                check_outs($sformatf("lock%0d", i), er0s[i], ~er0s[i], eovs[i], esel[i], eod[i], elst[i]);
            end
        end
`endif

        // Randomized run against a queue-based model of the merge.
        do_reset();
        q.delete();
        prio_m = 0;
        lock_m = -1;
        for (int s = 0; s < 2; s++) begin
            sv[s] = 1'b0; sd[s] = 8'h00; sl[s] = 1'b0;
        end
        for (int c = 0; c < 400; c++) begin
            int    g;
            logic  slot;
            logic  popped;
            beat_t h;
            @(posedge clk);
            #1;
            drive(sv[0], sd[0], sl[0], sv[1], sd[1], sl[1], ($urandom_range(0, 3) != 0));
            @(negedge clk);
            slot = (q.size() == 0) || out_ready;
            g = -1;
            if (lock_m >= 0)            g = sv[lock_m] ? lock_m : -1;
            else if (sv[0] && sv[1])    g = prio_m;
            else if (sv[0])             g = 0;
            else if (sv[1])             g = 1;
            if (!slot) g = -1;
            h = (q.size() != 0) ? q[0] : '{l: 1'b0, s: 1'b0, d: 8'h00};
            check_outs($sformatf("rand%0d", c), (g == 0), (g == 1), (q.size() != 0), h.s, h.d, h.l);
            popped = (q.size() != 0) && out_ready;
            if (popped) void'(q.pop_front());
            if (g >= 0) begin
                q.push_back('{l: sl[g], s: (g == 1), d: sd[g]});
`ifdef STREAM_MUX_LOCK_EN
                if (sl[g]) begin
                    lock_m = -1;
                    prio_m = 1 - g;
                end else begin
                    lock_m = g;
                end
`else
                prio_m = 1 - g;
`endif
                sv[g] = 1'b0;
            end
            for (int s = 0; s < 2; s++) begin
                if (!sv[s] && ($urandom_range(0, 2) != 0)) begin
                    sv[s] = 1'b1;
                    sd[s] = W'($urandom_range(0, 255));
                    sl[s] = 1'($urandom_range(0, 1));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stream_mux_2to1.md
# stream_mux_2to1

Two-input to one-output stream multiplexer with valid/ready handshakes, round-robin arbitration and a registered output stage. It is the merge side of the 1-bit select/split path: it interleaves two source streams onto one channel and tags each beat with `out_sel`, so a downstream select-driven demux can steer the beat back to its original branch. It sits between two producers and one shared consumer.

## Interface
- `DATA_W`, default 8: data width of every channel.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in0_valid` input 1: source 0 beat present.
- `in0_ready` output 1: source 0 beat accepted this cycle when high with `in0_valid`.
- `in0_data` input DATA_W: source 0 payload.
- `in1_valid`, `in1_ready`, `in1_data`: same as source 0, for source 1.
- `out_valid` output 1: output register holds a beat.
- `out_ready` input 1: consumer accepts the beat.
- `out_data` output DATA_W: payload of the registered beat.
- `out_sel` output 1: source index of the registered beat (0 or 1).

## Operation
- Transfer on any channel occurs on a rising edge with valid=1 and ready=1.
- `slot_free = ~out_valid | out_ready`. At most one input is granted per cycle.
- Grant rules:
  - Only one input valid: that input is granted.
  - Both inputs valid: the input named by the priority pointer `prio` is granted.
- `inK_ready = grant_K & slot_free`. It is combinational from both `in*_valid`, `out_valid`, `out_ready` and `prio`. Ready is never asserted for an ungranted input.
- On an accepted input beat: `out_data`/`out_sel` load the beat and its index, `out_valid` is set, and `prio` moves to the input not just served.
- When `out_valid & out_ready` and no input is accepted, `out_valid` clears.
- A beat accepted in the same cycle the held beat leaves replaces it with no bubble, giving 1 beat/cycle throughput.
- While `out_valid & ~out_ready`: `out_data` and `out_sel` hold stable and both input readies are 0.
- No beat is dropped or duplicated. Each accepted input beat appears exactly once on the output, in acceptance order.

## Timing
- Reset (async assert, sync release) values:
  - `out_valid`=0, `out_data`=0, `out_sel`=0.
  - `prio`=0 (source 0 first).
  - Lock state (when compiled in) is UNLOCKED.
- Latency: a beat accepted at edge N is on `out_*` from edge N until consumed. `out_valid` is high in the cycle after acceptance.
- Fairness: with both inputs continuously valid and `out_ready`=1, grants alternate 0,1,0,1… after reset.
- If reset asserts mid-transfer, the held beat is discarded. The upstream beat is not accepted on that edge.

## Configuration
- `STREAM_MUX_LOCK_EN`, when defined:
  - Adds ports `in0_last`, `in1_last` (inputs, 1 bit) and `out_last` (output, 1 bit, registered with the beat, reset 0).
  - Adds the arbitration state machine UNLOCKED → LOCK0/LOCK1:
    - An accepted beat with last=0 from input K enters LOCK_K.
    - In LOCK_K only input K can be granted, regardless of `prio` or the other input's valid.
    - An accepted beat from K with last=1 returns to UNLOCKED and flips `prio`.
    - A last=1 beat accepted in UNLOCKED leaves the state unchanged.
  - `prio` flips only on last=1 beats.
- Without the macro: the last ports are absent, arbitration is per beat, and there is no lock state.

## Structure
- Package `stream_mux_pkg` holds:
  - `src_e` enum (`SRC0`=1'b0, `SRC1`=1'b1), used for `prio` and `out_sel`.
  - `lock_state_e` (UNLOCKED, LOCK0, LOCK1).
  - `DATA_W_DEFAULT` = 8.
- One sub-module is natural: `stream_reg_slice`, the single-entry output register with the `slot_free` logic, parameterised by payload width. The payload is data, plus sel, plus last when the macro is defined.

## Test plan
- Reset: hold `rst_n`=0 with both inputs valid. Required: `out_valid`=0, `out_data`=0, both readies 0. After release, the first grant goes to in0.
- Single source: in1 sends 0x11, 0x22, 0x33 back-to-back, `out_ready`=1. Required: out beats 0x11, 0x22, 0x33 on consecutive cycles, each with `out_sel`=1.
- Contention: both valid continuously (in0=0xA0.., in1=0xB0..), `out_ready`=1. Required: 0xA0, 0xB0, 0xA1, 0xB1, `out_sel` 0,1,0,1.
- Backpressure: `out_ready`=0 for 3 cycles with a held beat 0x5C. Required: 0x5C stable, both readies 0, no new beat accepted. On `out_ready`=1 the next beat follows with no bubble.
- Async reset mid-stream: assert `rst_n` low while `out_valid`=1 and `out_ready`=0. Required: `out_valid` drops immediately, without waiting for a clock edge.
- With `STREAM_MUX_LOCK_EN`:
  - Input: in0 sends a 3-beat packet (last on beat 3) while in1 is valid throughout.
  - Required: three in0 beats are output with no in1 beat interleaved. The in1 beat comes next, and `out_last` is 1 only on in0 beat 3.
